// File: rtl/nmr_seq_pkg.sv
// nmr_seq_pkg: shared state encoding and default widths for the NMR scan sequencer.
package nmr_seq_pkg;

    localparam int SCAN_CNT_WIDTH_DEF = 16;
    localparam int DELAY_WIDTH_DEF    = 32;
    localparam int ACK_TIMEOUT_DEF    = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_REP_DLY,
        S_FINISH
    } seq_state_e;

endpackage

// File: rtl/nmr_scan_sequencer_if.sv
// nmr_scan_sequencer_if: host control and pulse-program handshake bundle of the scan sequencer.
interface nmr_scan_sequencer_if
    import nmr_seq_pkg::*;
#(
    parameter int SCAN_CNT_WIDTH = SCAN_CNT_WIDTH_DEF,
    parameter int DELAY_WIDTH    = DELAY_WIDTH_DEF
);
    logic                      SEQ_START;
    logic                      SEQ_ABORT;
    logic [SCAN_CNT_WIDTH-1:0] NUM_SCANS;
    logic [DELAY_WIDTH-1:0]    SCAN_DELAY;
    logic                      PHASE_CYC_EN;
    logic                      PP_FSMSTAT;
    logic                      PP_START;
    logic                      PP_PHASE_CYC;
    logic                      SEQ_BUSY;
    logic                      SEQ_DONE;
    logic                      SEQ_ERR;
    logic [SCAN_CNT_WIDTH-1:0] SCAN_IDX;

    modport master (
        output SEQ_START, SEQ_ABORT, NUM_SCANS, SCAN_DELAY, PHASE_CYC_EN, PP_FSMSTAT,
        input  PP_START, PP_PHASE_CYC, SEQ_BUSY, SEQ_DONE, SEQ_ERR, SCAN_IDX
    );

    modport slave (
        input  SEQ_START, SEQ_ABORT, NUM_SCANS, SCAN_DELAY, PHASE_CYC_EN, PP_FSMSTAT,
        output PP_START, PP_PHASE_CYC, SEQ_BUSY, SEQ_DONE, SEQ_ERR, SCAN_IDX
    );

endinterface

// File: rtl/nmr_seq_down_counter.sv
// nmr_seq_down_counter: loadable down counter that saturates at zero and flags it.
module nmr_seq_down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (en_i && cnt_q != '0) cnt_q <= cnt_q - WIDTH'(1);
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/nmr_scan_sequencer.sv
// nmr_scan_sequencer: launches NUM_SCANS pulse-program runs with repetition delay and phase cycling.
// Define NMR_SEQ_ACK_TIMEOUT_EN to enable the PP_FSMSTAT acknowledge timeout and SEQ_ERR.
module nmr_scan_sequencer
    import nmr_seq_pkg::*;
#(
    parameter int SCAN_CNT_WIDTH = SCAN_CNT_WIDTH_DEF,
    parameter int DELAY_WIDTH    = DELAY_WIDTH_DEF,
    parameter int ACK_TIMEOUT    = ACK_TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic RESET,
    nmr_scan_sequencer_if.slave bus
);

    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int CW = DELAY_WIDTH > AW ? DELAY_WIDTH : AW;

    seq_state_e                state_q;
    logic [SCAN_CNT_WIDTH-1:0] num_q, idx_q;
    logic [DELAY_WIDTH-1:0]    dly_q;
    logic                      ph_en_q, start_q, busy_q, done_q;
    logic                      cnt_load, cnt_en, cnt_zero, last_scan;
    logic [CW-1:0]             cnt_val;

    assign last_scan = idx_q >= num_q - SCAN_CNT_WIDTH'(1);

    // One counter serves both the repetition delay and the ack timeout; they never overlap.
`ifdef NMR_SEQ_ACK_TIMEOUT_EN
    logic err_q;
    assign cnt_load = (state_q == S_WAIT_DONE && !bus.PP_FSMSTAT) || state_q == S_LAUNCH;
    assign cnt_val  = state_q == S_LAUNCH ? CW'(ACK_TIMEOUT - 1) : CW'(dly_q) - CW'(1);
    assign cnt_en   = state_q == S_REP_DLY || state_q == S_WAIT_ACK;
    assign bus.SEQ_ERR = err_q;
`else
    assign cnt_load = state_q == S_WAIT_DONE && !bus.PP_FSMSTAT;
    assign cnt_val  = CW'(dly_q) - CW'(1);
    assign cnt_en   = state_q == S_REP_DLY;
    assign bus.SEQ_ERR = 1'b0;
`endif

    nmr_seq_down_counter #(.WIDTH(CW)) u_cnt (
        .clk    (CLK),
        .rst    (RESET),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .val_i  (cnt_val),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            dly_q   <= '0;
            ph_en_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NMR_SEQ_ACK_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus.SEQ_ABORT) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (bus.SEQ_START) begin
                        num_q   <= bus.NUM_SCANS;
                        dly_q   <= bus.SCAN_DELAY;
                        ph_en_q <= bus.PHASE_CYC_EN;
                        busy_q  <= 1'b1;
`ifdef NMR_SEQ_ACK_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        if (bus.NUM_SCANS == '0) state_q <= S_FINISH;
                        else begin
                            state_q <= S_LAUNCH;
                            idx_q   <= '0;
                            start_q <= 1'b1;
                        end
                    end
                    S_LAUNCH: state_q <= S_WAIT_ACK;
                    S_WAIT_ACK: if (bus.PP_FSMSTAT) state_q <= S_WAIT_DONE;
`ifdef NMR_SEQ_ACK_TIMEOUT_EN
                    else if (cnt_zero) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
`endif
                    S_WAIT_DONE: if (!bus.PP_FSMSTAT) begin
                        if (last_scan) state_q <= S_FINISH;
                        else if (dly_q == '0) begin
                            state_q <= S_LAUNCH;
                            idx_q   <= idx_q + SCAN_CNT_WIDTH'(1);
                            start_q <= 1'b1;
                        end else state_q <= S_REP_DLY;
                    end
                    S_REP_DLY: if (cnt_zero) begin
                        state_q <= S_LAUNCH;
                        idx_q   <= idx_q + SCAN_CNT_WIDTH'(1);
                        start_q <= 1'b1;
                    end
                    S_FINISH: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.PP_START     = start_q;
    assign bus.PP_PHASE_CYC = ph_en_q & idx_q[0];
    assign bus.SEQ_BUSY     = busy_q;
    assign bus.SEQ_DONE     = done_q;
    assign bus.SCAN_IDX     = idx_q;

endmodule

// File: tb/tb_nmr_scan_sequencer.sv
// tb_nmr_scan_sequencer: directed scenarios with an event scoreboard for PP_START, SEQ_DONE and SEQ_ERR.
module tb_nmr_scan_sequencer;
    import nmr_seq_pkg::*;

    typedef struct {
        int kind;
        int cyc;
        int idx;
        int ph;
    } ev_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    ev_t  exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   hold = 20;
    bit   ack_en = 1'b1;
    bit   err_prev = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    nmr_scan_sequencer_if #(.SCAN_CNT_WIDTH(16), .DELAY_WIDTH(32)) bus ();

    nmr_scan_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_ev(input int k, input int c, input int i, input int p);
        exp_q.push_back('{k, c, i, p});
    endtask

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_ev(input int k);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d idx=%0d ph=%0d, required none",
                     k, cyc, bus.SCAN_IDX, bus.PP_PHASE_CYC);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.idx != int'(bus.SCAN_IDX) || e.ph != int'(bus.PP_PHASE_CYC)) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d idx=%0d ph=%0d, required kind=%0d cyc=%0d idx=%0d ph=%0d",
                         k, cyc, bus.SCAN_IDX, bus.PP_PHASE_CYC, e.kind, e.cyc, e.idx, e.ph);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, int'(bus.PP_START), 0);
        check({tag, "_phase"}, int'(bus.PP_PHASE_CYC), 0);
        check({tag, "_busy"}, int'(bus.SEQ_BUSY), 0);
        check({tag, "_done"}, int'(bus.SEQ_DONE), 0);
        check({tag, "_err"}, int'(bus.SEQ_ERR), 0);
        check({tag, "_idx"}, int'(bus.SCAN_IDX), 0);
    endtask

    // Start is held for one cycle; the inputs are then scrambled so any failure to latch shows up.
    task automatic start_seq(input int n, input int d, input int p);
        bus.SEQ_START    = 1'b1;
        bus.NUM_SCANS    = 16'(n);
        bus.SCAN_DELAY   = 32'(d);
        bus.PHASE_CYC_EN = p[0];
        go_to(cyc + 1);
        bus.SEQ_START    = 1'b0;
        bus.NUM_SCANS    = 16'd7;
        bus.SCAN_DELAY   = 32'd1;
        bus.PHASE_CYC_EN = ~p[0];
    endtask

    // Pulse-program model: busy for `hold` cycles starting the cycle after each strobe.
    initial begin
        bus.PP_FSMSTAT = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.PP_START && ack_en) begin
                @(posedge CLK);
                #1;
                bus.PP_FSMSTAT = 1'b1;
                repeat (hold) @(posedge CLK);
                #1;
                bus.PP_FSMSTAT = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (bus.PP_START) check_ev(0);
        if (bus.SEQ_DONE) check_ev(1);
        if (bus.SEQ_ERR && !err_prev) check_ev(2);
        err_prev = bus.SEQ_ERR;
    end

    initial begin
        int s;
        bus.SEQ_START    = 1'b1;
        bus.SEQ_ABORT    = 1'b0;
        bus.NUM_SCANS    = 16'd3;
        bus.SCAN_DELAY   = 32'd5;
        bus.PHASE_CYC_EN = 1'b1;
        go_to(4);
        check_reset_outputs("reset");
        RESET = 1'b0;
        bus.SEQ_START = 1'b0;
        go_to(6);

        hold = 20;
        s = cyc;
        expect_ev(0, s + 1, 0, 0);
        expect_ev(0, s + 33, 1, 1);
        expect_ev(0, s + 65, 2, 0);
        expect_ev(1, s + 88, 2, 0);
        start_seq(3, 10, 1);
        go_to(s + 2);
        check("busy_running", int'(bus.SEQ_BUSY), 1);
        go_to(s + 95);
        check("idx_hold_after_done", int'(bus.SCAN_IDX), 2);
        check("busy_after_done", int'(bus.SEQ_BUSY), 0);

        s = cyc;
        expect_ev(1, s + 2, 2, 0);
        start_seq(0, 5, 0);
        check("busy_zero_scans", int'(bus.SEQ_BUSY), 1);
        go_to(s + 6);

        hold = 5;
        s = cyc;
        expect_ev(0, s + 1, 0, 0);
        expect_ev(0, s + 8, 1, 0);
        expect_ev(1, s + 16, 1, 0);
        start_seq(2, 0, 0);
        go_to(s + 22);

        s = cyc;
        expect_ev(0, s + 1, 0, 0);
        expect_ev(0, s + 18, 1, 1);
        start_seq(4, 10, 1);
        go_to(s + 10);
        bus.SEQ_START = 1'b1;
        bus.NUM_SCANS = 16'd1;
        go_to(s + 11);
        bus.SEQ_START = 1'b0;
        go_to(s + 26);
        bus.SEQ_ABORT = 1'b1;
        go_to(s + 27);
        bus.SEQ_ABORT = 1'b0;
        check("abort_busy", int'(bus.SEQ_BUSY), 0);
        check("abort_idx", int'(bus.SCAN_IDX), 1);
        go_to(s + 70);

        s = cyc;
        bus.SEQ_ABORT = 1'b1;
        bus.SEQ_START = 1'b1;
        bus.NUM_SCANS = 16'd1;
        go_to(s + 1);
        bus.SEQ_ABORT = 1'b0;
        bus.SEQ_START = 1'b0;
        check("abort_prio_busy", int'(bus.SEQ_BUSY), 0);
        go_to(s + 10);

        hold = 10;
        s = cyc;
        expect_ev(0, s + 1, 0, 0);
        expect_ev(0, s + 13, 1, 1);
        start_seq(3, 0, 1);
        go_to(s + 5);
        bus.SEQ_START = 1'b1;
        bus.NUM_SCANS = 16'd0;
        go_to(s + 6);
        bus.SEQ_START = 1'b0;
        go_to(s + 18);
        check("pre_reset_phase", int'(bus.PP_PHASE_CYC), 1);
        RESET = 1'b1;
        go_to(s + 19);
        check_reset_outputs("midreset");
        RESET = 1'b0;
        go_to(s + 40);

        ack_en = 1'b0;
        s = cyc;
        expect_ev(0, s + 1, 0, 0);
`ifdef NMR_SEQ_ACK_TIMEOUT_EN
        expect_ev(2, s + 66, 0, 0);
        start_seq(1, 0, 0);
        go_to(s + 65);
        check("err_before_timeout", int'(bus.SEQ_ERR), 0);
        go_to(s + 66);
        check("err_after_timeout", int'(bus.SEQ_ERR), 1);
        check("busy_after_timeout", int'(bus.SEQ_BUSY), 0);
`else
        start_seq(1, 0, 0);
        go_to(s + 100);
        check("busy_waiting_ack", int'(bus.SEQ_BUSY), 1);
        check("err_tied_low", int'(bus.SEQ_ERR), 0);
        bus.SEQ_ABORT = 1'b1;
        go_to(s + 101);
        bus.SEQ_ABORT = 1'b0;
        check("busy_after_abort", int'(bus.SEQ_BUSY), 0);
`endif
        ack_en = 1'b1;
        go_to(s + 110);

        s = cyc;
        expect_ev(1, s + 2, 0, 0);
        start_seq(0, 0, 0);
        check("err_cleared_on_start", int'(bus.SEQ_ERR), 0);
        go_to(s + 6);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nmr_scan_sequencer.md
NMR_SCAN_SEQUENCER -- requirements
Module: nmr_scan_sequencer

Interface
REQ-001 SHALL have parameter SCAN_CNT_WIDTH, default 16, width of scan count/index.
REQ-002 SHALL have parameter DELAY_WIDTH, default 32, width of repetition-delay counter.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 64, cycles allowed for PP_FSMSTAT to rise after PP_START.
REQ-004 CLK  input  1  system clock; single clock domain.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 SEQ_START  input  1  level; sampled high in IDLE starts a sequence.
REQ-007 SEQ_ABORT  input  1  level; abandons any running sequence.
REQ-008 NUM_SCANS  input  SCAN_CNT_WIDTH  scans per sequence.
REQ-009 SCAN_DELAY  input  DELAY_WIDTH  repetition delay between scans, CLK cycles.
REQ-010 PHASE_CYC_EN  input  1  enables alternating phase per scan.
REQ-011 PP_FSMSTAT  input  1  pulse-program busy flag, high while a scan runs.
REQ-012 PP_START  output  1  one-cycle start strobe to the pulse program.
REQ-013 PP_PHASE_CYC  output  1  phase select to the pulse program.
REQ-014 SEQ_BUSY  output  1  high in every state except IDLE.
REQ-015 SEQ_DONE  output  1  one-cycle pulse on normal completion.
REQ-016 SEQ_ERR  output  1  sticky; set on ack timeout, cleared on next accepted SEQ_START.
REQ-017 SCAN_IDX  output  SCAN_CNT_WIDTH  index of current/last scan.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, REP_DLY, FINISH.
REQ-019 SHALL latch NUM_SCANS, SCAN_DELAY, PHASE_CYC_EN in the cycle SEQ_START is accepted; later input changes have no effect on the running sequence.
REQ-020 IDLE with SEQ_START=1: NUM_SCANS=0 -> FINISH; else -> LAUNCH, SCAN_IDX=0, SEQ_ERR=0.
REQ-021 LAUNCH SHALL assert PP_START for exactly one cycle (registered; first PP_START the cycle after SEQ_START sampled) then -> WAIT_ACK.
REQ-022 WAIT_ACK: PP_FSMSTAT=1 -> WAIT_DONE; counter reaching ACK_TIMEOUT -> set SEQ_ERR, -> IDLE, no SEQ_DONE.
REQ-023 WAIT_DONE: PP_FSMSTAT=0 -> REP_DLY if SCAN_IDX < NUM_SCANS-1, else FINISH.
REQ-024 REP_DLY SHALL hold exactly SCAN_DELAY cycles (0 = zero cycles, direct to LAUNCH), increment SCAN_IDX on exit, -> LAUNCH.
REQ-025 No repetition delay SHALL follow the last scan.
REQ-026 PP_PHASE_CYC SHALL equal SCAN_IDX[0] when latched PHASE_CYC_EN=1, else 0; constant for the duration of a scan.
REQ-027 FINISH SHALL pulse SEQ_DONE one cycle, -> IDLE.
REQ-028 SEQ_START outside IDLE SHALL be ignored.
REQ-029 SEQ_ABORT=1 in any state SHALL force IDLE next cycle, PP_START=0, no SEQ_DONE; SEQ_ABORT has priority over SEQ_START in IDLE.
REQ-030 SCAN_IDX SHALL hold its value in IDLE after completion/abort.

Reset
REQ-031 RESET SHALL dominate all inputs: state IDLE, PP_START=0, PP_PHASE_CYC=0, SEQ_BUSY=0, SEQ_DONE=0, SEQ_ERR=0, SCAN_IDX=0, counters 0.
REQ-032 RESET mid-sequence SHALL abort without SEQ_DONE, effective next edge.

Configuration
REQ-033 Macro NMR_SEQ_ACK_TIMEOUT_EN: defined -> REQ-022 timeout active; undefined -> WAIT_ACK waits indefinitely for PP_FSMSTAT, SEQ_ERR tied 0, timeout counter absent.

Structure
REQ-034 State enumeration and default widths SHALL reside in shared package nmr_seq_pkg.
REQ-035 Repetition-delay and ack-timeout counting SHALL use one sub-module nmr_seq_down_counter (load, enable, zero flag).

Verification
REQ-036 NUM_SCANS=3, SCAN_DELAY=10, PHASE_CYC_EN=1, model FSMSTAT high 20 cycles -> 3 PP_START strobes, PP_PHASE_CYC 0,1,0, 10-cycle gaps, one SEQ_DONE, SCAN_IDX=2.
REQ-037 NUM_SCANS=0 -> no PP_START, SEQ_DONE pulse 2 cycles after SEQ_START.
REQ-038 NUM_SCANS=2, SCAN_DELAY=0 -> second PP_START one cycle after FSMSTAT falls (LAUNCH directly).
REQ-039 FSMSTAT held 0 after PP_START, macro defined -> SEQ_ERR=1 after 64 cycles, no SEQ_DONE; macro undefined -> remains in WAIT_ACK.
REQ-040 SEQ_ABORT during second scan's REP_DLY -> IDLE next cycle, SEQ_BUSY=0, no further PP_START, no SEQ_DONE.
REQ-041 RESET asserted in WAIT_DONE -> all outputs at reset values next cycle; SEQ_START during busy ignored.
